// File: rtl/spec_free_list_pkg.sv
// spec_free_list_pkg: shared rename configuration and free-list defaults
package spec_free_list_pkg;
    localparam int SIZE_PHYSICAL_LOG = 7;
    localparam int SIZE_RMT = 32;
    localparam int FREE_LIST_DEPTH = 64;
    localparam int FREE_LIST_PHYS_LOG = SIZE_PHYSICAL_LOG;
    localparam int FREE_LIST_FILL_BASE = SIZE_RMT;
    localparam int BUNDLE = 4;
    typedef logic [1:0] slotOffset_t;
endpackage

// File: rtl/fl_release_compact.sv
// fl_release_compact: maps four release valids to packed write offsets and a total
module fl_release_compact
    import spec_free_list_pkg::*;
(
    input  logic [3:0]                valid,
    output slotOffset_t [BUNDLE-1:0] offset,
    output logic [2:0]                total
);
    logic [2:0] run;
    always_comb begin
        run = '0;
        offset = '0;
        for (int k = 0; k < BUNDLE; k++) begin
            offset[k] = run[1:0];
            run = run + {2'b0, valid[k]};
        end
        total = run;
    end
endmodule

// File: rtl/spec_free_list.sv
// spec_free_list: circular free list of physical tags, pops 4 per bundle, accepts up to 4 releases
module spec_free_list
    import spec_free_list_pkg::*;
#(
    parameter int FL_DEPTH = FREE_LIST_DEPTH,
    parameter int PHYS_LOG = FREE_LIST_PHYS_LOG,
    parameter int FILL_BASE = FREE_LIST_FILL_BASE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        reqFreeReg_i,
    input  logic                        recoverFlag_i,
    input  logic                        releasedValid0_i,
    input  logic                        releasedValid1_i,
    input  logic                        releasedValid2_i,
    input  logic                        releasedValid3_i,
    input  logic [PHYS_LOG-1:0]         releasedPhyMap0_i,
    input  logic [PHYS_LOG-1:0]         releasedPhyMap1_i,
    input  logic [PHYS_LOG-1:0]         releasedPhyMap2_i,
    input  logic [PHYS_LOG-1:0]         releasedPhyMap3_i,
    output logic [PHYS_LOG-1:0]         freeReg0_o,
    output logic [PHYS_LOG-1:0]         freeReg1_o,
    output logic [PHYS_LOG-1:0]         freeReg2_o,
    output logic [PHYS_LOG-1:0]         freeReg3_o,
    output logic                        freeListEmpty_o,
    output logic [$clog2(FL_DEPTH):0]   freeCount_o
);
    localparam int PTR = $clog2(FL_DEPTH);
    localparam int CW = PTR + 2;

    logic [PHYS_LOG-1:0] mem [FL_DEPTH];
    logic [PTR-1:0] headPtr, tailPtr, nextTail;
    logic [PTR:0] count;
    logic [CW-1:0] nextCountWide;
    logic [3:0] relValid;
    logic [BUNDLE-1:0][PHYS_LOG-1:0] relTag;
    slotOffset_t [BUNDLE-1:0] relOffset;
    logic [2:0] relCount;
    logic [BUNDLE-1:0][PTR-1:0] rdAddr, wrAddr;
    logic doPop;

    assign relValid = {releasedValid3_i, releasedValid2_i, releasedValid1_i, releasedValid0_i};
    assign relTag = {releasedPhyMap3_i, releasedPhyMap2_i, releasedPhyMap1_i, releasedPhyMap0_i};

    fl_release_compact u_compact (
        .valid  (relValid),
        .offset (relOffset),
        .total  (relCount)
    );

    always_comb begin
        rdAddr = '0;
        wrAddr = '0;
        for (int k = 0; k < BUNDLE; k++) begin
            rdAddr[k] = headPtr + PTR'(k);
            wrAddr[k] = tailPtr + PTR'(relOffset[k]);
        end
    end

    assign freeReg0_o = mem[rdAddr[0]];
    assign freeReg1_o = mem[rdAddr[1]];
    assign freeReg2_o = mem[rdAddr[2]];
    assign freeReg3_o = mem[rdAddr[3]];
    assign freeListEmpty_o = count < (PTR+1)'(BUNDLE);
    assign freeCount_o = count;

    assign doPop = reqFreeReg_i && !freeListEmpty_o && !recoverFlag_i;
    assign nextTail = tailPtr + PTR'(relCount);
    assign nextCountWide = CW'(count) + CW'(relCount) - (doPop ? CW'(BUNDLE) : CW'(0));

    always_ff @(posedge clk) begin
        if (reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count <= (PTR+1)'(FL_DEPTH);
        end else begin
            assert (recoverFlag_i || nextCountWide <= CW'(FL_DEPTH));
            tailPtr <= nextTail;
            headPtr <= recoverFlag_i ? nextTail : doPop ? headPtr + PTR'(BUNDLE) : headPtr;
            count <= recoverFlag_i ? (PTR+1)'(FL_DEPTH) : nextCountWide[PTR:0];
        end
    end

    // Overflowing releases are still written; the assertion above flags them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++) mem[i] <= PHYS_LOG'(FILL_BASE + i);
        end else begin
            for (int k = 0; k < BUNDLE; k++) if (relValid[k]) mem[wrAddr[k]] <= relTag[k];
        end
    end
endmodule

// File: tb/tb_spec_free_list.sv
// tb_spec_free_list: directed checks of pop, release compaction, wrap, recovery and reset
module tb_spec_free_list;
    logic clk = 0;
    logic reset, req, rec;
    logic [3:0] relV;
    logic [6:0] relT [4];
    logic [6:0] fr [4];
    logic empty;
    logic [6:0] cnt;
    int nComp = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    spec_free_list dut (
        .clk (clk), .reset (reset), .reqFreeReg_i (req), .recoverFlag_i (rec),
        .releasedValid0_i (relV[0]), .releasedValid1_i (relV[1]),
        .releasedValid2_i (relV[2]), .releasedValid3_i (relV[3]),
        .releasedPhyMap0_i (relT[0]), .releasedPhyMap1_i (relT[1]),
        .releasedPhyMap2_i (relT[2]), .releasedPhyMap3_i (relT[3]),
        .freeReg0_o (fr[0]), .freeReg1_o (fr[1]), .freeReg2_o (fr[2]), .freeReg3_o (fr[3]),
        .freeListEmpty_o (empty), .freeCount_o (cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        nComp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkRegs(input string tag, input int a, input int b, input int c, input int d);
        chk({tag, " freeReg0"}, fr[0], a);
        chk({tag, " freeReg1"}, fr[1], b);
        chk({tag, " freeReg2"}, fr[2], c);
        chk({tag, " freeReg3"}, fr[3], d);
    endtask

    task automatic step(input logic r, input logic c, input logic [3:0] v,
                        input int t0, input int t1, input int t2, input int t3);
        req = r; rec = c; relV = v;
        relT[0] = 7'(t0); relT[1] = 7'(t1); relT[2] = 7'(t2); relT[3] = 7'(t3);
        @(posedge clk); #1;
        req = 0; rec = 0; relV = '0;
    endtask

    initial begin
        reset = 1; req = 0; rec = 0; relV = '0;
        for (int k = 0; k < 4; k++) relT[k] = '0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        step(0, 0, 4'b0000, 0, 0, 0, 0);
        chk("reset count", cnt, 64);
        chk("reset empty", empty, 0);
        chkRegs("reset", 32, 33, 34, 35);

        for (int i = 0; i < 16; i++) begin
            chk("pop freeReg0", fr[0], 32 + 4 * i);
            chk("pop freeReg3", fr[3], 35 + 4 * i);
            step(1, 0, 4'b0000, 0, 0, 0, 0);
        end
        chk("drained count", cnt, 0);
        chk("drained empty", empty, 1);
        step(1, 0, 4'b0000, 0, 0, 0, 0);
        chk("ignored pop count", cnt, 0);
        chk("ignored pop freeReg0", fr[0], 32);

        step(0, 0, 4'b1101, 10, 11, 12, 13);
        chk("sparse release count", cnt, 3);
        chk("sparse release empty", empty, 1);
        step(0, 0, 4'b0001, 14, 0, 0, 0);
        chk("fourth release empty", empty, 0);
        chkRegs("compacted", 10, 12, 13, 14);

        step(0, 0, 4'b1111, 20, 21, 22, 23);
        chk("count eight", cnt, 8);
        step(1, 0, 4'b0011, 50, 51, 0, 0);
        chk("pop plus release count", cnt, 6);
        chkRegs("pop plus release", 20, 21, 22, 23);

        for (int p = 10; p < 62; p += 4) step(0, 0, 4'b1111, p + 64, p + 65, p + 66, p + 67);
        chk("fill to tail 62 count", cnt, 58);
        step(0, 1, 4'b0000, 0, 0, 0, 0);
        chk("recover count", cnt, 64);
        chkRegs("head wrap read", 94, 95, 10, 12);
        step(1, 0, 4'b0000, 0, 0, 0, 0);
        chk("pop across wrap count", cnt, 60);
        chkRegs("after wrap pop", 13, 14, 20, 21);
        step(0, 0, 4'b1111, 100, 101, 102, 103);
        chk("wrap write count", cnt, 64);
        chk("wrap write head kept", fr[0], 13);

        repeat (3) step(1, 0, 4'b0000, 0, 0, 0, 0);
        chk("three pops count", cnt, 52);
        chk("three pops freeReg0", fr[0], 78);
        step(1, 1, 4'b0100, 0, 0, 40, 0);
        chk("recover with release count", cnt, 64);
        chkRegs("head at new tail", 14, 20, 21, 22);
        repeat (15) step(1, 0, 4'b0000, 0, 0, 0, 0);
        chk("fifteen pops count", cnt, 4);
        chk("fifteen pops empty", empty, 0);
        chkRegs("wrapped writes", 101, 102, 103, 40);
        step(1, 0, 4'b0000, 0, 0, 0, 0);
        chk("last pop count", cnt, 0);
        chk("last pop empty", empty, 1);

        reset = 1; req = 1; rec = 1; relV = 4'b1111;
        for (int k = 0; k < 4; k++) relT[k] = 7'(5 + k);
        @(posedge clk); #1;
        reset = 0; req = 0; rec = 0; relV = '0;
        chk("midrun reset count", cnt, 64);
        chk("midrun reset empty", empty, 0);
        chkRegs("midrun reset", 32, 33, 34, 35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end
endmodule

// File: doc/spec_free_list.md
SPEC_FREE_LIST -- requirements
Module: spec_free_list

Interface
REQ-001 The block SHALL have parameter FL_DEPTH, default 64, giving the number of free-list entries (power of two).
REQ-002 The block SHALL have parameter PHYS_LOG, default 7, giving the physical register tag width.
REQ-003 The block SHALL have parameter FILL_BASE, default 32, giving the tag held by entry 0 at reset (tags FILL_BASE..FILL_BASE+FL_DEPTH-1).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 reqFreeReg_i  input  1  rename requests one bundle of 4 free tags this cycle.
REQ-007 recoverFlag_i  input  1  exception or mispredict recovery.
REQ-008 releasedValid0_i..releasedValid3_i  input  1 each  retire-side release valid, slot 0 oldest.
REQ-009 releasedPhyMap0_i..releasedPhyMap3_i  input  PHYS_LOG each  released physical tag.
REQ-010 freeReg0_o..freeReg3_o  output  PHYS_LOG each  tags at head, head+1, head+2, head+3.
REQ-011 freeListEmpty_o  output  1  high when fewer than 4 tags are available.
REQ-012 freeCount_o  output  log2(FL_DEPTH)+1  current number of free tags.

Function
REQ-013 The storage SHALL be a circular buffer of FL_DEPTH tags with headPtr, tailPtr (log2(FL_DEPTH) bits, modulo wrap) and a count register.
REQ-014 freeReg0_o..3_o SHALL be combinational reads at headPtr+0..3 modulo FL_DEPTH, with zero-cycle latency.
REQ-015 freeListEmpty_o SHALL equal (count < 4), combinationally.
REQ-016 A pop SHALL occur when reqFreeReg_i and not freeListEmpty_o and not recoverFlag_i; a pop advances headPtr by 4 and removes 4 from count (all-or-nothing).
REQ-017 Valid releases SHALL be compacted in slot order and written at tailPtr, tailPtr+1, ... mod FL_DEPTH; tailPtr advances by N = popcount(releasedValid0..3).
REQ-018 With a pop and N releases in the same cycle, count SHALL become count-4+N.
REQ-019 Releases SHALL be accepted when count+N exceeds FL_DEPTH; the block SHALL NOT drop them, and the overflow condition is a simulation assertion failure.
REQ-020 On recoverFlag_i, same-cycle releases SHALL still be written; headPtr SHALL become the post-write tailPtr and count SHALL become FL_DEPTH (slots consumed speculatively still hold their tags).
REQ-021 Recovery SHALL take priority over a pop in the same cycle.
REQ-022 Head and tail SHALL wrap from FL_DEPTH-1 to 0 without bubbles; a 4-entry read or write straddling the wrap SHALL be handled in one cycle.

Reset
REQ-023 On reset: headPtr=0, tailPtr=0, count=FL_DEPTH, entry i=FILL_BASE+i.
REQ-024 After reset: freeListEmpty_o=0, freeCount_o=FL_DEPTH, freeReg0..3_o=FILL_BASE..FILL_BASE+3.
REQ-025 Reset SHALL override recovery, pop and release in the same cycle; reset in the middle of operation SHALL restore the REQ-023 state in one cycle.

Structure
REQ-026 FL_DEPTH, PHYS_LOG and FILL_BASE defaults SHALL come from the shared configuration package, next to the SIZE_PHYSICAL_LOG and SIZE_RMT constants.
REQ-027 Release compaction (4 valids to per-slot write offsets plus N) SHALL be one sub-module, fl_release_compact.
REQ-028 The storage SHALL use the team's multi-port SRAM style with 4 read ports and 4 write ports.

Verification
REQ-029 Reset, then idle: freeCount_o=64, freeReg0..3_o=32,33,34,35, freeListEmpty_o=0.
REQ-030 16 consecutive pops: tags 32..95 are returned in order; freeListEmpty_o=1 and freeCount_o=0 after the 16th pop; a further request is ignored.
REQ-031 With count=0, release valids 1,0,1,1 with tags 10,11,12,13: freeCount_o=3 and freeListEmpty_o=1; one more release of tag 14 -> freeReg0..3_o=10,12,13,14.
REQ-032 Pop and release of 2 tags in the same cycle with count=8: count becomes 6; the wrap-around at headPtr=62 yields entries 62,63,0,1.
REQ-033 After 3 pops, recovery plus release of tag 40 in the same cycle: freeCount_o=64, headPtr equals the new tailPtr, and no pop occurs.
REQ-034 Reset asserted during a cycle with recovery, pop and release all active: the next cycle shows exactly the REQ-024 values.
